gshare_bp_ckpt: RTL

// Parametrised gshare conditional-branch predictor with a speculative global history register (GHR).

---
 rtl/gshare_bp_ckpt.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gshare_bp_ckpt.sv
// gshare conditional-branch predictor with a speculative, checkpointed global history.
// The counter table is re-initialised by a row sweep after reset and after every flush.
module gshare_bp_ckpt #(
  parameter int NR_ENTRIES      = 1024,
  parameter int INSTR_PER_FETCH = 2,
  parameter int HIST_BITS       = 12,
  parameter int CTR_BITS        = 2,
  parameter int VLEN            = 39,
  parameter int RVC             = 1,
  parameter int IDX_BITS        = $clog2(NR_ENTRIES / INSTR_PER_FETCH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [IDX_BITS-1:0]        pred_index_o,
  output logic [HIST_BITS-1:0]       pred_ghr_o,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic [IDX_BITS-1:0]        upd_index_i,
  input  logic [HIST_BITS-1:0]       upd_ghr_i,
  input  logic                       upd_taken_i,
  input  logic                       upd_mispredict_i,
  output logic                       init_busy_o
);

  localparam int NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int IPF_BITS = $clog2(INSTR_PER_FETCH);
  localparam int SLOT_W   = (IPF_BITS > 0) ? IPF_BITS : 1;
  localparam int OFFSET   = (RVC != 0) ? 1 : 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [IDX_BITS-1:0] LAST_ROW = IDX_BITS'(NR_ROWS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q;
  logic [IDX_BITS-1:0]   sweep_ptr_q;
  logic [HIST_BITS-1:0]  ghr_q, ghr_nxt;
  logic [IDX_BITS-1:0]   fold, rd_idx;
  logic [SLOT_W-1:0]     upd_slot;
  logic [CTR_BITS:0]     upd_cur;
  logic [CTR_BITS-1:0]   ctr_nxt;
  logic                  upd_en;

  // Each entry is {valid, ctr}; storage is deliberately left without reset.
  logic [CTR_BITS:0] table_q [NR_ROWS][INSTR_PER_FETCH];

  function automatic logic [HIST_BITS-1:0] shift_in(input logic [HIST_BITS-1:0] h, input logic b);
    logic [HIST_BITS:0] t;
    t = {h, b};
    return t[HIST_BITS-1:0];
  endfunction

  // History bit i lands in index bit i mod IDX_BITS: chunked XOR with zero padding.
  always_comb begin
    fold = '0;
    for (int i = 0; i < HIST_BITS; i++) fold[i % IDX_BITS] ^= ghr_q[i];
  end

  assign rd_idx = vpc_i[IDX_BITS+IPF_BITS+OFFSET-1 -: IDX_BITS] ^ fold;

  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    pred_index_o = '0;
    if (state_q == IDLE) begin
      pred_index_o = rd_idx;
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        pred_valid_o[s] = table_q[rd_idx][s][CTR_BITS];
        pred_taken_o[s] = table_q[rd_idx][s][CTR_BITS-1];
      end
    end
  end

  assign pred_ghr_o  = ghr_q;
  assign init_busy_o = (state_q == SWEEP);

  generate
    if (RVC != 0 && INSTR_PER_FETCH > 1) begin : g_slot
      assign upd_slot = upd_pc_i[OFFSET+IPF_BITS-1:OFFSET];
    end else begin : g_slot0
      assign upd_slot = '0;
    end
  endgenerate

  assign upd_en  = (state_q == IDLE) && upd_valid_i && !debug_mode_i && !flush_bp_i;
  assign upd_cur = table_q[upd_index_i][upd_slot];

  always_comb begin
    ctr_nxt = upd_cur[CTR_BITS-1:0];
    if (upd_taken_i) begin
      if (upd_cur[CTR_BITS-1:0] != CTR_MAX) ctr_nxt = upd_cur[CTR_BITS-1:0] + 1'b1;
    end else begin
      if (upd_cur[CTR_BITS-1:0] != '0) ctr_nxt = upd_cur[CTR_BITS-1:0] - 1'b1;
    end
  end

  // A mispredict restores the checkpoint and discards any same-cycle speculative shift.
  always_comb begin
    ghr_nxt = ghr_q;
    if (state_q == IDLE && !debug_mode_i) begin
      if (upd_valid_i && upd_mispredict_i) ghr_nxt = shift_in(upd_ghr_i, upd_taken_i);
      else if (spec_valid_i)               ghr_nxt = shift_in(ghr_q, spec_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == SWEEP) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) table_q[sweep_ptr_q][s] <= {1'b0, CTR_WEAK};
    end else if (upd_en) begin
      table_q[upd_index_i][upd_slot] <= {1'b1, ctr_nxt};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_bp_i) begin
      state_q     <= SWEEP;
      sweep_ptr_q <= '0;
      ghr_q       <= '0;
    end else begin
      ghr_q <= ghr_nxt;
      if (state_q == SWEEP) begin
        sweep_ptr_q <= sweep_ptr_q + 1'b1;
        if (sweep_ptr_q == LAST_ROW) state_q <= IDLE;
      end
    end
  end

endmodule
